stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//   Stopwatch controller: sequences an internal clk-enable prescaler (CLK_HZ -> TICK_HZ)
//   and a BCD mm:ss.t time counter. User controls start/stop, clear and (optionally) lap.
//   Sits between the debounced button front-end and the 7-segment display mux.
// PARAMETERS
//   CLK_HZ   100_000_000  system clock frequency
//   TICK_HZ  10           count resolution; DIV = CLK_HZ/TICK_HZ (integer, >= 2)
// PORTS
//   clk         in   1  system clock, all logic on posedge
//   rst_n       in   1  reset, asynchronous, ACTIVE-HIGH (despite the name)
//   start_stop  in   1  1-cycle sync pulse, toggles run/pause
//   clear       in   1  1-cycle sync pulse, zero the time (not honoured while running)
//   lap         in   1  1-cycle sync pulse, freeze/unfreeze display (LAP_EN only)
//   running     out  1  1 while in RUN
//   tick        out  1  1-cycle pulse at each TICK_HZ increment
//   rollover    out  1  1-cycle pulse when time wraps 59:59.9 -> 00:00.0
//   lap_active  out  1  1 while display is frozen
//   tenths      out  4  BCD 0-9      sec_ones out 4  BCD 0-9     sec_tens out 3  0-5
//   min_ones    out  4  BCD 0-9      min_tens out 3  0-5
// BEHAVIOUR
//   - Reset (async, rst_n=1): state IDLE, prescaler=0, time=00:00.0, all outputs 0.
//   - FSM: IDLE -start_stop-> RUN; RUN -start_stop-> PAUSE; PAUSE -start_stop-> RUN;
//     clear in IDLE/PAUSE -> IDLE; clear in RUN ignored.
//   - Simultaneous start_stop+clear: IDLE/PAUSE -> clear wins (IDLE, zeros);
//     RUN -> start_stop wins (PAUSE), clear dropped.
//   - Prescaler: ceil(log2 DIV) bits, counts 0..DIV-1 only in RUN; held in PAUSE
//     (resume keeps phase); zeroed on entry to IDLE.
//   - tick=1 in the cycle prescaler==DIV-1 while in RUN; prescaler->0 on the next edge.
//   - Time increments on the edge closing a tick cycle; new value visible cycle after tick.
//   - Digit carry chain: tenths 9->0 carries sec_ones; 9->0 -> sec_tens; 5->0 -> min_ones;
//     9->0 -> min_tens; 5->0 wraps to 00:00.0, rollover asserted the cycle after that edge
//     for exactly 1 cycle; counting continues.
//   - Pulse arriving on the same cycle as tick: tick's increment is kept, then state changes
//     (e.g. stop on tick cycle -> value includes that increment, enter PAUSE).
//   - Outputs registered; running reflects state register (1 cycle after start_stop).
//   - Reset mid-operation: immediate return to reset values, no partial update.
// CONFIGURATION
//   STOPWATCH_LAP_EN defined: lap in RUN toggles lap_active; while 1 the digit outputs
//     hold the snapshot taken at the lap edge, the live counter keeps running; second lap
//     releases (outputs show live value next cycle). Leaving RUN does not release;
//     clear (->IDLE) or reset forces lap_active=0. lap in IDLE/PAUSE ignored.
//   Not defined: lap ignored, lap_active tied 0, digits always show live counter.
// TESTING  (bench uses CLK_HZ=100, TICK_HZ=10 -> DIV=10)
//   1. Reset, start_stop @cycle 0 -> running=1 @1; first tick cycle 10; after 100 cycles
//      of RUN time=00:01.0, 10 tick pulses counted.
//   2. RUN 5 cycles, stop, wait 20, start -> first tick exactly 5 RUN cycles after resume;
//      no tick during PAUSE.
//   3. Run 36000 ticks -> time 00:00.0 after wrap, rollover high exactly 1 cycle,
//      intermediate check 59:59.9 one tick earlier.
//   4. PAUSE at 00:03.4, start_stop+clear same cycle -> IDLE, 00:00.0, running=0;
//      in RUN same pulse pair -> PAUSE, time kept.
//   5. Assert rst_n mid-RUN between edges -> all outputs 0 without waiting for clk.
//   6. LAP_EN: lap at 00:02.0, run 30 ticks -> digits stay 00:02.0, lap again -> 00:05.0;
//      build without macro: lap has no effect, lap_active=0.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control/display bundle between the button front-end, the
// stopwatch controller and the 7-segment display mux.
interface stopwatch_ctrl_if;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic       running;
  logic       tick;
  logic       rollover;
  logic       lap_active;
  logic [3:0] tenths;
  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [2:0] min_tens;

  // Front-end / bench side: issues button pulses, watches time and status
  modport master (
    output start_stop, clear, lap,
    input  running, tick, rollover, lap_active,
    input  tenths, sec_ones, sec_tens, min_ones, min_tens
  );

  // Controller side
  modport slave (
    input  start_stop, clear, lap,
    output running, tick, rollover, lap_active,
    output tenths, sec_ones, sec_tens, min_ones, min_tens
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE sequencer, CLK_HZ -> TICK_HZ prescaler
// and BCD mm:ss.t counter with wrap at 59:59.9.
// Optional lap/freeze display feature enabled by defining STOPWATCH_LAP_EN.
// Note: rst_n is an asynchronous ACTIVE-HIGH reset despite its name.
module stopwatch_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10
) (
  input logic           clk,
  input logic           rst_n,
  stopwatch_ctrl_if.slave bus
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    ten_q, ten_d, so_q, so_d, mo_q, mo_d;
  logic [2:0]    st_q, st_d, mt_q, mt_d;
  logic          running_q, running_d;
  logic          tick_q, tick_d;
  logic          roll_q, roll_d;
  logic          lap_q, lap_d;
  logic [17:0]   disp_q, disp_d;
  logic          tick_now_s;
  logic          clear_go_s;
  logic          wrap_s;

  // A tick cycle closes on this edge; clear is only honoured outside RUN
  assign tick_now_s = (state_q == S_RUN) && (pre_q == PRE_LAST);
  assign clear_go_s = (state_q != S_RUN) && bus.clear;
  assign wrap_s     = tick_now_s && (ten_q == 4'd9) && (so_q == 4'd9) &&
                      (st_q == 3'd5) && (mo_q == 4'd9) && (mt_q == 3'd5);

  // Next-state logic; clear beats start_stop outside RUN, start_stop wins in RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clear)           state_d = S_IDLE;
        else if (bus.start_stop) state_d = S_RUN;
        else                     state_d = S_IDLE;
      end
      S_RUN: begin
        if (bus.start_stop) state_d = S_PAUSE;
        else                state_d = S_RUN;
      end
      S_PAUSE: begin
        if (bus.clear)           state_d = S_IDLE;
        else if (bus.start_stop) state_d = S_RUN;
        else                     state_d = S_PAUSE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prescaler: counts only in RUN, holds phase in PAUSE, zeroed in IDLE
  always_comb begin
    pre_d = pre_q;
    if (state_d == S_IDLE) begin
      pre_d = {PW{1'b0}};
    end else if (state_q == S_RUN) begin
      if (pre_q == PRE_LAST) pre_d = {PW{1'b0}};
      else                   pre_d = pre_q + PW'(1);
    end else begin
      pre_d = pre_q;
    end
  end

  // BCD time counter with full carry chain; the tick increment lands before any stop
  always_comb begin
    ten_d = ten_q;
    so_d  = so_q;
    st_d  = st_q;
    mo_d  = mo_q;
    mt_d  = mt_q;
    if (clear_go_s) begin
      ten_d = 4'd0;
      so_d  = 4'd0;
      st_d  = 3'd0;
      mo_d  = 4'd0;
      mt_d  = 3'd0;
    end else if (tick_now_s) begin
      if (ten_q != 4'd9) begin
        ten_d = ten_q + 4'd1;
      end else begin
        ten_d = 4'd0;
        if (so_q != 4'd9) begin
          so_d = so_q + 4'd1;
        end else begin
          so_d = 4'd0;
          if (st_q != 3'd5) begin
            st_d = st_q + 3'd1;
          end else begin
            st_d = 3'd0;
            if (mo_q != 4'd9) begin
              mo_d = mo_q + 4'd1;
            end else begin
              mo_d = 4'd0;
              if (mt_q != 3'd5) mt_d = mt_q + 3'd1;
              else              mt_d = 3'd0;
            end
          end
        end
      end
    end else begin
      ten_d = ten_q;
    end
  end

  // Status outputs and the displayed digits (frozen while a lap is held)
  always_comb begin
    running_d = (state_d == S_RUN);
    tick_d    = (state_d == S_RUN) && (pre_d == PRE_LAST);
    roll_d    = wrap_s;
`ifdef STOPWATCH_LAP_EN
    if (clear_go_s)                        lap_d = 1'b0;
    else if ((state_q == S_RUN) && bus.lap) lap_d = ~lap_q;
    else                                   lap_d = lap_q;
`else
    lap_d = 1'b0;
`endif
    if (lap_d) disp_d = disp_q;
    else       disp_d = {mt_d, mo_d, st_d, so_d, ten_d};
  end

`ifndef STOPWATCH_LAP_EN
  logic lap_unused_s;
  assign lap_unused_s = bus.lap;
`endif

  // Core state: FSM, prescaler and live time counter
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      pre_q   <= {PW{1'b0}};
      ten_q   <= 4'd0;
      so_q    <= 4'd0;
      st_q    <= 3'd0;
      mo_q    <= 4'd0;
      mt_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      ten_q   <= ten_d;
      so_q    <= so_d;
      st_q    <= st_d;
      mo_q    <= mo_d;
      mt_q    <= mt_d;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      roll_q    <= 1'b0;
      lap_q     <= 1'b0;
      disp_q    <= 18'd0;
    end else begin
      running_q <= running_d;
      tick_q    <= tick_d;
      roll_q    <= roll_d;
      lap_q     <= lap_d;
      disp_q    <= disp_d;
    end
  end

  assign bus.running    = running_q;
  assign bus.tick       = tick_q;
  assign bus.rollover   = roll_q;
  assign bus.lap_active = lap_q;
  assign bus.min_tens   = disp_q[17:15];
  assign bus.min_ones   = disp_q[14:11];
  assign bus.sec_tens   = disp_q[10:8];
  assign bus.sec_ones   = disp_q[7:4];
  assign bus.tenths     = disp_q[3:0];
endmodule
